// File: rtl/sensor_cond_pkg.sv
// Shared widths and helpers for the sensor conditioning block.
// Imported by sensor_cond and cad_sync_edge.
package sensor_cond_pkg;

    localparam int TORQ_W = 12;
    localparam int CADV_W = 5;
    localparam logic [CADV_W-1:0] CADV_MAX = 5'd31;

    // Saturating increment so a fast crank pins the edge count at 31 instead of wrapping.
    function automatic logic [CADV_W-1:0] sat_inc5(input logic [CADV_W-1:0] val, input logic inc);
        logic [CADV_W-1:0] res;
        res = val;
        if (inc && (val != CADV_MAX)) begin
            res = val + 5'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cad_sync_edge.sv
// Synchronizes the asynchronous crank cadence pin and produces a one-cycle rise strobe.
// Define SENSOR_COND_CAD_FILT_EN to insert a 3-clock glitch filter after the synchronizer.
module cad_sync_edge
    import sensor_cond_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cadence_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic lvl;
    logic lvl_dly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            lvl_dly_q <= 1'b0;
        end else begin
            sync1_q   <= cadence_i;
            sync2_q   <= sync1_q;
            lvl_dly_q <= lvl;
        end
    end

`ifdef SENSOR_COND_CAD_FILT_EN
    logic       filt_q;
    logic       filt_d;
    logic [1:0] filt_cnt_q;
    logic [1:0] filt_cnt_d;

    // The filtered level flips only once sync2 has disagreed with it for 3 straight clocks.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = 2'd0;
        if (sync2_q != filt_q) begin
            if (filt_cnt_q == 2'd2) begin
                filt_d = sync2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= 2'd0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    assign rise_o = lvl & ~lvl_dly_q;

endmodule

// File: rtl/sensor_cond.sv
// Conditions rider inputs: exponential torque average and windowed cadence edge count.
// SENSOR_COND_CAD_FILT_EN (optional) enables the cadence glitch filter in cad_sync_edge.
module sensor_cond
    import sensor_cond_pkg::*;
#(
    parameter int CAD_WIN_W = 22,
    parameter int AVG_SHFT  = 5,
    parameter int NP_THRESH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cadence,
    input  logic [11:0] torque,
    input  logic        torque_vld,
    output logic [11:0] avg_torque,
    output logic [4:0]  cadence_vec,
    output logic        not_pedaling,
    output logic        cad_upd
);

    localparam int ACC_W = TORQ_W + AVG_SHFT;

    logic                 rise;
    logic                 terminal;
    logic [CADV_W-1:0]    cnt_inc;

    logic [CAD_WIN_W-1:0] win_q;
    logic [CAD_WIN_W-1:0] win_d;
    logic [CADV_W-1:0]    edge_cnt_q;
    logic [CADV_W-1:0]    edge_cnt_d;
    logic [CADV_W-1:0]    cadv_q;
    logic [CADV_W-1:0]    cadv_d;
    logic                 np_q;
    logic                 np_d;
    logic                 upd_q;
    logic                 upd_d;

    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_d;
    logic [TORQ_W-1:0]    avg_q;
    logic [TORQ_W-1:0]    avg_d;

    cad_sync_edge u_sync (
        .clk       (clk),
        .rst       (rst),
        .cadence_i (cadence),
        .rise_o    (rise)
    );

    assign terminal = &win_q;
    assign cnt_inc  = sat_inc5(edge_cnt_q, rise);

    // A rise in the terminal cycle folds into the window that is closing, so the snapshot uses cnt_inc.
    always_comb begin
        win_d      = win_q + CAD_WIN_W'(1);
        edge_cnt_d = cnt_inc;
        cadv_d     = cadv_q;
        np_d       = np_q;
        upd_d      = 1'b0;
        if (terminal) begin
            edge_cnt_d = '0;
            cadv_d     = cnt_inc;
            np_d       = (int'(cnt_inc) < NP_THRESH);
            upd_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q      <= '0;
            edge_cnt_q <= '0;
            cadv_q     <= '0;
            np_q       <= 1'b1;
            upd_q      <= 1'b0;
        end else begin
            win_q      <= win_d;
            edge_cnt_q <= edge_cnt_d;
            cadv_q     <= cadv_d;
            np_q       <= np_d;
            upd_q      <= upd_d;
        end
    end

    // The average is taken from the next accumulator value so it trails torque_vld by one clock.
    always_comb begin
        acc_d = acc_q;
        if (torque_vld) begin
            acc_d = acc_q - (acc_q >> AVG_SHFT) + ACC_W'(torque);
        end
        avg_d = acc_d[ACC_W-1:AVG_SHFT];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

    assign avg_torque   = avg_q;
    assign cadence_vec  = cadv_q;
    assign not_pedaling = np_q;
    assign cad_upd      = upd_q;

endmodule

// File: tb/tb_sensor_cond.sv
// Self-checking bench for sensor_cond with a 256-clock cadence window.
// Honours SENSOR_COND_CAD_FILT_EN when choosing cadence latency and glitch expectations.
module tb_sensor_cond;

    localparam int WIN = 256;
`ifdef SENSOR_COND_CAD_FILT_EN
    localparam int FLT_LAT = 3;
    localparam bit FILT_ON = 1'b1;
`else
    localparam int FLT_LAT = 0;
    localparam bit FILT_ON = 1'b0;
`endif
    localparam int SAT_PER = FILT_ON ? 6 : 4;

    typedef struct {
        logic        vld;
        logic [11:0] t;
        logic [11:0] expAvg;
    } torqVec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cadence = 1'b0;
    logic        torque_vld = 1'b0;
    logic [11:0] torque = 12'h000;
    logic [11:0] avg_torque;
    logic [4:0]  cadence_vec;
    logic        not_pedaling;
    logic        cad_upd;

    int checks = 0;
    int errors = 0;
    int cyc;
    int riseCnt[128];
    int curExpVec = 0;
    logic prevCad = 1'b0;
    bit glitchMode = 1'b0;
    int modelAcc = 0;
    int expAvg = 0;
    torqVec_t tbl[6];

    always #5 clk = ~clk;

    sensor_cond #(
        .CAD_WIN_W (8),
        .AVG_SHFT  (5),
        .NP_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cadence      (cadence),
        .torque       (torque),
        .torque_vld   (torque_vld),
        .avg_torque   (avg_torque),
        .cadence_vec  (cadence_vec),
        .not_pedaling (not_pedaling),
        .cad_upd      (cad_upd)
    );

    // Clock edges since reset release; the window closes on every multiple of WIN.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // A rise driven after edge c is counted at edge c+3 (+3 with the filter) and belongs to the window closing at or after it.
    task automatic recordRise(input int c);
        int w;
        w = (c + 3 + FLT_LAT + WIN - 1) / WIN;
        if (w < 128) riseCnt[w]++;
    endtask

    task automatic applyStimulus(input logic cad, input logic vld, input logic [11:0] t);
        checkOutput("avg_torque", avg_torque, expAvg);
        if (cad && !prevCad && !(FILT_ON && glitchMode)) recordRise(cyc);
        prevCad    = cad;
        cadence    = cad;
        torque_vld = vld;
        torque     = t;
        if (vld) modelAcc = modelAcc - modelAcc / 32 + int'(t);
        expAvg = (modelAcc / 32) & 'hFFF;
    endtask

    task automatic randStep(input logic cad);
        @(negedge clk);
        applyStimulus(cad, 1'($urandom_range(0, 1)), 12'($urandom));
    endtask

    task automatic runUntil(input int target, input int per, input int hiStart, input int hiEnd);
        for (int k = 0; k < 4 * WIN && cyc < target; k++) begin
            @(negedge clk);
            applyStimulus(per != 0 && (cyc % per) >= hiStart && (cyc % per) < hiEnd,
                          1'($urandom_range(0, 1)), 12'($urandom));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_avg"}, avg_torque, 0);
        checkOutput({tag, "_vec"}, cadence_vec, 0);
        checkOutput({tag, "_np"}, not_pedaling, 1);
        checkOutput({tag, "_upd"}, cad_upd, 0);
    endtask

    task automatic resetMidRun();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("rst_mid");
        modelAcc  = 0;
        expAvg    = 0;
        curExpVec = 0;
        for (int i = 0; i < 128; i++) riseCnt[i] = 0;
        @(negedge clk);
        cadence    = 1'b0;
        prevCad    = 1'b0;
        torque_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Window snapshot, threshold flag and update strobe are compared every cycle against the rise tally.
    always @(negedge clk) begin : monitor
        bit expUpd;
        if (!rst) begin
            expUpd = (cyc % WIN == 0) && (cyc != 0);
            if (expUpd) curExpVec = (riseCnt[cyc / WIN] > 31) ? 31 : riseCnt[cyc / WIN];
            checkOutput("cad_upd", cad_upd, int'(expUpd));
            checkOutput("cadence_vec", cadence_vec, curExpVec);
            checkOutput("not_pedaling", not_pedaling, int'(curExpVec < 2));
        end
    end

    initial begin
        int base;
        int winEnd;
        int prevExp;
        int diff;

        tbl[0] = '{1'b1, 12'h800, 12'h040};
        tbl[1] = '{1'b1, 12'h800, 12'h07E};
        tbl[2] = '{1'b0, 12'hFFF, 12'h07E};
        tbl[3] = '{1'b1, 12'h800, 12'h0BA};
        tbl[4] = '{1'b1, 12'h000, 12'h0B4};
        tbl[5] = '{1'b1, 12'hFFF, 12'h12E};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs("rst_init");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, tbl[i].vld, tbl[i].t);
            @(posedge clk);
            #1;
            checkOutput($sformatf("avg_table%0d", i), avg_torque, tbl[i].expAvg);
        end

        repeat (400) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 12'h800);
        end
        @(posedge clk);
        #1;
        diff = int'(avg_torque) - 'h800;
        checks++;
        if (diff > 1 || diff < -1) begin
            errors++;
            $display("[TB] FAIL avg_settle: got 0x%0h, expected 0x800 +/- 1", avg_torque);
        end

        repeat (40) begin
            prevExp = expAvg;
            @(negedge clk);
            applyStimulus(1'b0, 1'b1, 12'h000);
            @(posedge clk);
            #1;
            checks++;
            if (int'(avg_torque) > prevExp) begin
                errors++;
                $display("[TB] FAIL avg_decay: got 0x%0h, expected at most 0x%0h", avg_torque, prevExp);
            end
        end

        runUntil(2 * WIN + 40, 32, 8, 24);
        resetMidRun();

        runUntil(3 * WIN, 32, 8, 24);
        checkOutput("square_vec", cadence_vec, 8);
        checkOutput("square_np", not_pedaling, 0);

        runUntil(5 * WIN, SAT_PER, SAT_PER / 2, SAT_PER);
        checkOutput("sat_vec", cadence_vec, 31);
        runUntil(7 * WIN, 0, 0, 0);
        checkOutput("idle_vec", cadence_vec, 0);
        checkOutput("idle_np", not_pedaling, 1);

        for (int k = 0; k < 2 * WIN; k++) begin
            @(negedge clk);
            if ((cyc % WIN) == 253 - FLT_LAT) break;
            applyStimulus(1'b0, 1'b0, 12'h000);
        end
        winEnd = ((cyc + 3 + FLT_LAT + WIN - 1) / WIN) * WIN;
        applyStimulus(1'b1, 1'b0, 12'h000);
        repeat (8) randStep(1'b1);
        runUntil(winEnd, 0, 0, 0);
        checkOutput("edge_term_vec", cadence_vec, 1);
        checkOutput("edge_term_np", not_pedaling, 1);
        runUntil(winEnd + WIN, 0, 0, 0);
        checkOutput("edge_next_vec", cadence_vec, 0);

        base = cyc;
        runUntil(base + 20, 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            repeat (8) randStep(1'b1);
            repeat (8) randStep(1'b0);
        end
        runUntil(base + WIN, 0, 0, 0);
        checkOutput("thresh2_vec", cadence_vec, 2);
        checkOutput("thresh2_np", not_pedaling, 0);

        glitchMode = 1'b1;
        runUntil(cyc + 2 * WIN, 32, 8, 10);
        glitchMode = 1'b0;
        checkOutput("glitch_vec", cadence_vec, FILT_ON ? 0 : 8);

        base = cyc + 3 * WIN;
        for (int k = 0; k < 200 && cyc < base; k++) begin
            repeat ($urandom_range(3, 12)) randStep(1'b1);
            repeat ($urandom_range(3, 12)) randStep(1'b0);
        end
        runUntil(((cyc / WIN) + 2) * WIN, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
